// File: rtl/mem_resp_pkg.sv
// Shared types and constants for the mem_responder slice.
package mem_resp_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        ACCESS = 2'd2,
        ACK    = 2'd3
    } state_t;

    localparam int          WCNT_W  = 3;
    localparam logic [15:0] TXN_MAX = 16'hFFFF;

endpackage

// File: rtl/mem_resp_array.sv
// Word storage for mem_responder: synchronous write, registered read into rdata.
// MEM_RESP_PARITY_EN adds one stored even-parity bit per word and a read-side check.
module mem_resp_array #(
    parameter int AW = 15,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
`ifdef MEM_RESP_PARITY_EN
    input  logic          pinj,
`endif
    output logic [DW-1:0] rdata,
    output logic          err
);
`ifdef MEM_RESP_PARITY_EN
    localparam int WW = DW + 1;
`else
    localparam int WW = DW;
`endif

    logic [WW-1:0] mem [0:(2**AW)-1];
    logic [WW-1:0] wword;
    logic [WW-1:0] rword;

`ifdef MEM_RESP_PARITY_EN
    // pinj flips the stored bit so the next read of this word reports a mismatch.
    assign wword = {(^wdata) ^ pinj, wdata};
`else
    assign wword = wdata;
`endif
    assign rword = mem[addr];

    // Contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (en && we) begin
            mem[addr] <= wword;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata <= '0;
        end else if (en && !we) begin
            rdata <= rword[DW-1:0];
        end
    end

`ifdef MEM_RESP_PARITY_EN
    // Cleared on every non-read edge so err can only be high in the ack cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err <= 1'b0;
        end else begin
            err <= en && !we && ((^rword[DW-1:0]) != rword[DW]);
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: rtl/mem_responder.sv
// Request/acknowledge memory responder: FSM, LAT wait counter, request latches, txn counter.
// Define MEM_RESP_PARITY_EN to add the pinj port and stored-parity error reporting.
module mem_responder
    import mem_resp_pkg::*;
#(
    parameter int AW  = 15,
    parameter int DW  = 16,
    parameter int LAT = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
`ifdef MEM_RESP_PARITY_EN
    input  logic          pinj,
`endif
    output logic          ack,
    output logic [DW-1:0] rdata,
    output logic          busy,
    output logic          err,
    output logic [15:0]   txn_cnt,
    output state_t        dbg_state
);
    // Handshake: req is sampled only in IDLE and we/addr/wdata(/pinj) are latched on that
    // edge; ack pulses for one cycle per transaction. A requester that keeps req high
    // through the ack cycle gets a second transaction.
    localparam logic [WCNT_W-1:0] WAIT_LOAD = WCNT_W'((LAT > 0) ? LAT - 1 : 0);

    state_t            state_q, state_d;
    logic [WCNT_W-1:0] wcnt_q, wcnt_d;
    logic              capture;
    logic              access;
    logic              we_q;
    logic [AW-1:0]     addr_q;
    logic [DW-1:0]     wdata_q;
    logic [15:0]       txn_q;
`ifdef MEM_RESP_PARITY_EN
    logic              pinj_q;
`endif

    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        capture = 1'b0;
        access  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req) begin
                    capture = 1'b1;
                    wcnt_d  = WAIT_LOAD;
                    state_d = (LAT == 0) ? ACCESS : WAIT;
                end
            end
            WAIT: begin
                if (wcnt_q == '0) begin
                    state_d = ACCESS;
                end else begin
                    wcnt_d = wcnt_q - WCNT_W'(1);
                end
            end
            ACCESS: begin
                access  = 1'b1;
                state_d = ACK;
            end
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            wcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
`ifdef MEM_RESP_PARITY_EN
            pinj_q  <= 1'b0;
`endif
        end else if (capture) begin
            we_q    <= we;
            addr_q  <= addr;
            wdata_q <= wdata;
`ifdef MEM_RESP_PARITY_EN
            pinj_q  <= pinj;
`endif
        end
    end

    // Counts on the ACCESS edge, i.e. the edge entering ACK.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            txn_q <= '0;
        end else if (access && (txn_q != TXN_MAX)) begin
            txn_q <= txn_q + 16'd1;
        end
    end

    mem_resp_array #(
        .AW (AW),
        .DW (DW)
    ) u_array (
        .clk   (clk),
        .rst   (rst),
        .en    (access),
        .we    (we_q),
        .addr  (addr_q),
        .wdata (wdata_q),
`ifdef MEM_RESP_PARITY_EN
        .pinj  (pinj_q),
`endif
        .rdata (rdata),
        .err   (err)
    );

    assign ack       = (state_q == ACK);
    assign busy      = (state_q != IDLE);
    assign txn_cnt   = txn_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: LAT=2 instance for most scenarios, LAT=0 instance for held req.
`timescale 1ns/1ps
module tb_mem_responder;
    import mem_resp_pkg::*;

    localparam int AW  = 15;
    localparam int DW  = 16;
    localparam int LAT = 2;
`ifdef MEM_RESP_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic          clk   = 1'b0;
    logic          rst   = 1'b0;
    logic          req   = 1'b0;
    logic          req0  = 1'b0;
    logic          we    = 1'b0;
    logic [AW-1:0] addr  = '0;
    logic [DW-1:0] wdata = '0;
`ifdef MEM_RESP_PARITY_EN
    logic          pinj  = 1'b0;
`endif
    logic          ack, busy, err, ack0, busy0, err0;
    logic [DW-1:0] rdata, rdata0;
    logic [15:0]   txn_cnt, txn_cnt0;
    state_t        dbg_state, dbg_state0;

    int checks   = 0;
    int failures = 0;

    // Reference model: word contents, injected-parity flags, last read data, counters.
    logic [DW-1:0] model_mem  [int];
    bit            model_pe   [int];
    logic [DW-1:0] model_mem0 [int];
    logic [DW-1:0] model_rd   = '0;
    logic [DW-1:0] model_rd0  = '0;
    int            model_cnt  = 0;
    int            model_cnt0 = 0;
    logic [DW-1:0] exp_q [$];

    logic [AW-1:0] pool [8] = '{15'h0000, 15'h0001, 15'h0005, 15'h0010,
                               15'h7FFF, 15'h0123, 15'h4000, 15'h2AAA};

    always #5 clk = ~clk;

    mem_responder #(.AW(AW), .DW(DW), .LAT(LAT)) dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
`ifdef MEM_RESP_PARITY_EN
        .pinj(pinj),
`endif
        .ack(ack), .rdata(rdata), .busy(busy), .err(err), .txn_cnt(txn_cnt),
        .dbg_state(dbg_state)
    );

    mem_responder #(.AW(AW), .DW(DW), .LAT(0)) dut0 (
        .clk(clk), .rst(rst), .req(req0), .we(we), .addr(addr), .wdata(wdata),
`ifdef MEM_RESP_PARITY_EN
        .pinj(pinj),
`endif
        .ack(ack0), .rdata(rdata0), .busy(busy0), .err(err0), .txn_cnt(txn_cnt0),
        .dbg_state(dbg_state0)
    );

    function automatic int sat16(input int v);
        return (v > 65535) ? 65535 : v;
    endfunction

    task automatic model_reset();
        model_cnt  = 0;
        model_cnt0 = 0;
        model_rd   = '0;
        model_rd0  = '0;
    endtask

    // One transaction; inputs are scrambled right after capture. n = edges from capture to ack.
    task automatic do_txn(input bit sel, input bit w, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input bit pj,
                          output logic [DW-1:0] rd, output logic e, output int n);
        @(negedge clk);
        we = w; addr = a; wdata = d;
`ifdef MEM_RESP_PARITY_EN
        pinj = pj;
`endif
        if (sel) req0 = 1'b1; else req = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req = 1'b0; req0 = 1'b0;
        we = ~w; addr = '1; wdata = '1;
`ifdef MEM_RESP_PARITY_EN
        pinj = ~pj;
`endif
        n = 0;
        while (!(sel ? ack0 : ack) && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!(sel ? ack0 : ack)) begin
            failures++;
            $display("FAIL ack_timeout sel=%0d addr=%h waited=%0d", sel, a, n);
        end
        rd = sel ? rdata0 : rdata;
        e  = sel ? err0 : err;
        if (sel) begin
            if (w) model_mem0[int'(a)] = d;
            else   model_rd0 = model_mem0[int'(a)];
            model_cnt0 = sat16(model_cnt0 + 1);
        end else begin
            if (w) begin
                model_mem[int'(a)] = d;
                model_pe[int'(a)]  = pj;
            end else begin
                model_rd = model_mem[int'(a)];
            end
            model_cnt = sat16(model_cnt + 1);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({ack, busy, err, rdata, txn_cnt} !== '0 || dbg_state !== IDLE) begin
            failures++;
            $display("FAIL reset_hold ack=%b busy=%b err=%b rdata=%h cnt=%h st=%0d exp all 0/IDLE",
                     ack, busy, err, rdata, txn_cnt, dbg_state);
        end
        rst = 1'b1;
        model_reset();
        @(negedge clk);
        checks++;
        if ({ack, busy, err, rdata, txn_cnt} !== '0 || dbg_state !== IDLE) begin
            failures++;
            $display("FAIL reset_release ack=%b busy=%b err=%b rdata=%h cnt=%h exp 0", ack, busy, err, rdata, txn_cnt);
        end
        checks++;
        if ({ack0, busy0, err0, rdata0, txn_cnt0} !== '0 || dbg_state0 !== IDLE) begin
            failures++;
            $display("FAIL reset_lat0 ack=%b busy=%b err=%b rdata=%h cnt=%h exp 0", ack0, busy0, err0, rdata0, txn_cnt0);
        end
    endtask

    task automatic test_write_read();
        logic [DW-1:0] rd;
        logic          e;
        int            n;
        do_txn(1'b0, 1'b1, 15'h0005, 16'hA5A5, 1'b0, rd, e, n);
        checks++;
        if (n !== LAT + 1) begin
            failures++;
            $display("FAIL wr_latency got=%0d exp=%0d", n, LAT + 1);
        end
        @(negedge clk);
        checks++;
        if (ack !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL ack_pulse_width ack=%b busy=%b exp 0/0 one cycle after ack", ack, busy);
        end
        do_txn(1'b0, 1'b0, 15'h0005, 16'h0000, 1'b0, rd, e, n);
        checks++;
        if (n !== LAT + 1 || rd !== 16'hA5A5) begin
            failures++;
            $display("FAIL rd_after_wr lat=%0d rdata=%h exp lat=%0d rdata=a5a5", n, rd, LAT + 1);
        end
        checks++;
        if (txn_cnt !== 16'(model_cnt) || model_cnt != 2) begin
            failures++;
            $display("FAIL txn_cnt_two got=%0d exp=2", txn_cnt);
        end
    endtask

    task automatic test_reset_midwait();
        logic [DW-1:0] rd;
        logic          e;
        int            n;
        bit            seen = 1'b0;
        do_txn(1'b0, 1'b1, 15'h0010, 16'h1111, 1'b0, rd, e, n);
        @(negedge clk);
        we = 1'b1; addr = 15'h0010; wdata = 16'h2222; req = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req = 1'b0;
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (ack) seen = 1'b1;
        end
        checks++;
        if (seen || busy !== 1'b0 || txn_cnt !== 16'h0000) begin
            failures++;
            $display("FAIL reset_midwait ack_seen=%b busy=%b cnt=%h exp 0/0/0", seen, busy, txn_cnt);
        end
        rst = 1'b1;
        model_reset();
        do_txn(1'b0, 1'b0, 15'h0010, 16'h0000, 1'b0, rd, e, n);
        checks++;
        if (rd !== model_mem[int'(15'h0010)] || rd !== 16'h1111) begin
            failures++;
            $display("FAIL reset_no_write rdata=%h exp=1111", rd);
        end
        checks++;
        if (txn_cnt !== 16'(model_cnt)) begin
            failures++;
            $display("FAIL cnt_after_reset got=%0d exp=%0d", txn_cnt, model_cnt);
        end
    endtask

    task automatic test_input_change();
        logic [DW-1:0] rd;
        logic [DW-1:0] keep;
        logic          e;
        int            n;
        keep = 16'($urandom_range(0, 16'hFFFE));
        do_txn(1'b0, 1'b1, 15'h7FFF, keep, 1'b0, rd, e, n);
        do_txn(1'b0, 1'b1, 15'h0001, 16'h1234, 1'b0, rd, e, n);
        do_txn(1'b0, 1'b0, 15'h0001, 16'h0000, 1'b0, rd, e, n);
        checks++;
        if (rd !== 16'h1234) begin
            failures++;
            $display("FAIL latched_write rdata=%h exp=1234", rd);
        end
        do_txn(1'b0, 1'b0, 15'h7FFF, 16'h0000, 1'b0, rd, e, n);
        checks++;
        if (rd !== keep) begin
            failures++;
            $display("FAIL scrambled_addr_untouched rdata=%h exp=%h", rd, keep);
        end
    endtask

    task automatic test_boundary();
        logic [DW-1:0] rd;
        logic          e;
        int            n;
        for (int pass = 0; pass < 2; pass++) begin
            do_txn(1'b0, 1'b1, 15'h0000, (pass == 0) ? 16'hFFFF : 16'h0000, 1'b0, rd, e, n);
            do_txn(1'b0, 1'b1, 15'h7FFF, (pass == 0) ? 16'h0000 : 16'hFFFF, 1'b0, rd, e, n);
            do_txn(1'b0, 1'b0, 15'h0000, 16'h0000, 1'b0, rd, e, n);
            checks++;
            if (rd !== ((pass == 0) ? 16'hFFFF : 16'h0000)) begin
                failures++;
                $display("FAIL boundary_lo pass=%0d rdata=%h", pass, rd);
            end
            do_txn(1'b0, 1'b0, 15'h7FFF, 16'h0000, 1'b0, rd, e, n);
            checks++;
            if (rd !== ((pass == 0) ? 16'h0000 : 16'hFFFF)) begin
                failures++;
                $display("FAIL boundary_hi pass=%0d rdata=%h", pass, rd);
            end
        end
        // Jump the counter close to saturation instead of running 70000 transactions.
        @(negedge clk);
        force dut.txn_q = 16'hFFFD;
        #1;
        release dut.txn_q;
        model_cnt = 65533;
        for (int i = 0; i < 4; i++) begin
            do_txn(1'b0, 1'b0, 15'h0000, 16'h0000, 1'b0, rd, e, n);
            checks++;
            if (txn_cnt !== 16'(model_cnt)) begin
                failures++;
                $display("FAIL txn_saturate step=%0d got=%h exp=%h", i, txn_cnt, 16'(model_cnt));
            end
        end
        checks++;
        if (txn_cnt !== 16'hFFFF) begin
            failures++;
            $display("FAIL txn_hold got=%h exp=ffff", txn_cnt);
        end
    endtask

    task automatic test_held_req();
        logic [DW-1:0] rd;
        logic [DW-1:0] v;
        logic          e;
        int            n;
        v = 16'($urandom);
        do_txn(1'b1, 1'b1, 15'h0042, v, 1'b0, rd, e, n);
        checks++;
        if (n !== 1) begin
            failures++;
            $display("FAIL lat0_latency got=%0d exp=1", n);
        end
        @(negedge clk);
        we = 1'b0; addr = 15'h0042; req0 = 1'b1;
        for (int c = 0; c <= 10; c++) begin
            @(negedge clk);
            checks++;
            if (ack0 !== (c % 3 == 1) || busy0 !== (c % 3 != 2)) begin
                failures++;
                $display("FAIL held_req_pattern cyc=%0d ack=%b busy=%b exp ack=%b busy=%b",
                         c, ack0, busy0, (c % 3 == 1), (c % 3 != 2));
            end
            if (c % 3 == 1) begin
                model_cnt0 = sat16(model_cnt0 + 1);
                checks++;
                if (rdata0 !== v) begin
                    failures++;
                    $display("FAIL held_req_rdata cyc=%0d rdata=%h exp=%h", c, rdata0, v);
                end
            end
        end
        req0 = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checks++;
            if (ack0 !== 1'b0 || busy0 !== 1'b0) begin
                failures++;
                $display("FAIL held_req_stop cyc=%0d ack=%b busy=%b exp 0/0", c, ack0, busy0);
            end
        end
        checks++;
        if (txn_cnt0 !== 16'(model_cnt0)) begin
            failures++;
            $display("FAIL held_req_cnt got=%0d exp=%0d", txn_cnt0, model_cnt0);
        end
    endtask

    task automatic test_random();
        logic [DW-1:0] rd;
        logic [DW-1:0] d;
        logic [AW-1:0] a;
        logic          e;
        logic          exp_e;
        bit            w;
        bit            pj;
        int            n;
        for (int i = 0; i < 60; i++) begin
            a  = pool[$urandom_range(0, 7)];
            w  = ($urandom_range(0, 1) == 1) || !model_mem.exists(int'(a));
            d  = 16'($urandom);
            pj = PAR_EN ? 1'($urandom_range(0, 1)) : 1'b0;
            exp_q.push_back(w ? model_rd : model_mem[int'(a)]);
            exp_e = !w && PAR_EN && model_pe[int'(a)];
            do_txn(1'b0, w, a, d, pj, rd, e, n);
            checks++;
            if (rd !== exp_q.pop_front() || e !== exp_e || n !== LAT + 1) begin
                failures++;
                $display("FAIL random i=%0d we=%b addr=%h rdata=%h err=%b lat=%0d exp err=%b lat=%0d",
                         i, w, a, rd, e, n, exp_e, LAT + 1);
            end
            checks++;
            if (txn_cnt !== 16'(model_cnt)) begin
                failures++;
                $display("FAIL random_cnt i=%0d got=%h exp=%h", i, txn_cnt, 16'(model_cnt));
            end
        end
    endtask

`ifdef MEM_RESP_PARITY_EN
    task automatic test_parity();
        logic [DW-1:0] rd;
        logic          e;
        int            n;
        do_txn(1'b0, 1'b1, 15'h00FF, 16'h00FF, 1'b1, rd, e, n);
        do_txn(1'b0, 1'b0, 15'h00FF, 16'h0000, 1'b0, rd, e, n);
        checks++;
        if (e !== 1'b1 || rd !== 16'h00FF) begin
            failures++;
            $display("FAIL parity_inject err=%b rdata=%h exp err=1 rdata=00ff", e, rd);
        end
        @(negedge clk);
        checks++;
        if (err !== 1'b0) begin
            failures++;
            $display("FAIL parity_err_width err=%b exp=0 after ack", err);
        end
        do_txn(1'b0, 1'b1, 15'h00FF, 16'h00FF, 1'b0, rd, e, n);
        do_txn(1'b0, 1'b0, 15'h00FF, 16'h0000, 1'b0, rd, e, n);
        checks++;
        if (e !== 1'b0 || rd !== 16'h00FF) begin
            failures++;
            $display("FAIL parity_clean err=%b rdata=%h exp err=0 rdata=00ff", e, rd);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_write_read();
        test_reset_midwait();
        test_input_change();
        test_boundary();
        test_held_req();
        test_random();
`ifdef MEM_RESP_PARITY_EN
        test_parity();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
